// File: rtl/spi_master_ctrl.sv
// SPI master: one MSB-first frame per StartFlag rising edge, with chip-select setup and hold.
// SCK is derived from CLK_IN by a half-period counter; CPOL/CPHA select idle level and sampling edge.
module spi_master_ctrl #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BitRate_Kbps = 3000,
  parameter int CPOL         = 0,
  parameter int CPHA         = 0,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  CLK_IN,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  StartFlag,
  input  logic [DATA_WIDTH-1:0] Master_TxData,
  input  logic                  MISO,
  output logic                  SCK,
  output logic                  MOSI,
  output logic                  ChipSel,
  output logic [DATA_WIDTH-1:0] Master_RxData,
  output logic                  DataValid,
  output logic                  SPI_Done,
  output logic                  Busy
);
  localparam int   CPB      = CLK_FREQ_HZ / (BitRate_Kbps * 1000);
  localparam int   HALF     = (CPB / 2 < 1) ? 1 : CPB / 2;
  localparam int   CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int   EW       = $clog2(2 * DATA_WIDTH);
  localparam logic IDLE_SCK = (CPOL != 0);
  localparam logic SAMPLE_ON_LEAD = (CPHA == 0);

  typedef enum logic [2:0] {IDLE, CS_SETUP, TRANSFER, CS_HOLD, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [EW-1:0]           edge_cnt;
  logic [DATA_WIDTH-1:0]   tx_sh, rx_sh;
  logic                    start_q;
  logic                    half_done, lead, last_edge;

  assign half_done = (cnt == CW'(HALF - 1));
  assign lead      = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EW'(2 * DATA_WIDTH - 1));

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      edge_cnt      <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      start_q       <= 1'b0;
      SCK           <= IDLE_SCK;
      MOSI          <= 1'b0;
      ChipSel       <= 1'b1;
      Master_RxData <= '0;
      DataValid     <= 1'b0;
      SPI_Done      <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      start_q   <= StartFlag;
      DataValid <= 1'b0;
      SPI_Done  <= 1'b0;
      if (!EN && state != IDLE) begin
        // abort: release the slave immediately, keep the last good frame
        state   <= IDLE;
        cnt     <= '0;
        SCK     <= IDLE_SCK;
        ChipSel <= 1'b1;
        Busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (StartFlag && !start_q && EN) begin
            state   <= CS_SETUP;
            cnt     <= '0;
            tx_sh   <= Master_TxData;
            rx_sh   <= '0;
            ChipSel <= 1'b0;
            Busy    <= 1'b1;
            if (CPHA == 0) MOSI <= Master_TxData[DATA_WIDTH-1];
          end
          CS_SETUP: if (half_done) begin
            state    <= TRANSFER;
            cnt      <= '0;
            edge_cnt <= '0;
          end else cnt <= cnt + 1'b1;
          TRANSFER: if (half_done) begin
            cnt      <= '0;
            SCK      <= ~SCK;
            edge_cnt <= edge_cnt + 1'b1;
            if (lead == SAMPLE_ON_LEAD)
              rx_sh <= {rx_sh[DATA_WIDTH-2:0], MISO};
            else if (CPHA != 0) begin
              MOSI  <= tx_sh[DATA_WIDTH-1];
              tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
            end else if (!last_edge) begin
              // CPHA=0 already presented the MSB, so the trailing edge moves to the next bit
              MOSI  <= tx_sh[DATA_WIDTH-2];
              tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
            end
            if (last_edge) state <= CS_HOLD;
          end else cnt <= cnt + 1'b1;
          CS_HOLD: if (half_done) begin
            state         <= DONE;
            cnt           <= '0;
            ChipSel       <= 1'b1;
            Busy          <= 1'b0;
            Master_RxData <= rx_sh;
            DataValid     <= 1'b1;
            SPI_Done      <= 1'b1;
          end else cnt <= cnt + 1'b1;
          // one cycle where start edges are ignored, so a request overlapping SPI_Done is dropped
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
